// File: rtl/cbi980_axil_regs.sv
// rtl/cbi980_axil_regs.sv - AXI4-Lite register front-end for the CBI980 I2S core
// CFG bank, back-pressured TX sample push and sticky event flags with interrupt.
module cbi980_axil_regs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [ADDR_W-1:0]      awaddr,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [ADDR_W-1:0]      araddr,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [NREG*DATA_W-1:0] cfg_o,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [DATA_W-1:0]      evt_i,
  output logic                   irq
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam logic [IDX_W-1:0] TX_IDX  = IDX_W'(NREG);
  localparam logic [IDX_W-1:0] EVT_IDX = IDX_W'(NREG + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_PUSH, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t           wstate_q, wstate_d;
  rstate_t           rstate_q, rstate_d;
  logic              live_q, live_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] cfg_q [NREG];
  logic [DATA_W-1:0] cfg_d [NREG];
  logic [DATA_W-1:0] evt_q, evt_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              aw_hs, w_hs, ar_hs;
  logic [DATA_W-1:0] strb_mask;
  logic [DATA_W-1:0] clr_mask;
  logic [IDX_W-1:0]  ar_idx;
  logic              unused_ok;

  assign unused_ok = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};
  assign ar_idx    = araddr[ADDR_W-1:LSB];

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
  end

  // Write channel: AW and W are captured independently, then executed as one access.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    tx_data_d = tx_data_q;
    clr_mask  = '0;
    awready   = 1'b0;
    wready    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      cfg_d[k] = cfg_q[k];
    end

    unique case (wstate_q)
      W_IDLE: begin
        awready = live_q & ~aw_held_q;
        wready  = live_q & ~w_held_q;
        aw_hs   = awvalid & awready;
        w_hs    = wvalid & wready;
        if (aw_hs) begin
          aw_idx_d  = awaddr[ADDR_W-1:LSB];
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_held_d = 1'b1;
        end
        if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
          wstate_d = W_EXEC;
        end
      end
      W_EXEC: begin
        bresp_d  = RESP_OKAY;
        wstate_d = W_RESP;
        if (aw_idx_q < TX_IDX) begin
          for (int k = 0; k < NREG; k++) begin
            if (aw_idx_q == IDX_W'(k)) begin
              cfg_d[k] = (cfg_q[k] & ~strb_mask) | (wdata_q & strb_mask);
            end
          end
        end else if (aw_idx_q == TX_IDX) begin
          // A partial sample would be meaningless to the serialiser, so reject it.
          if (&wstrb_q) begin
            tx_data_d = wdata_q;
            wstate_d  = W_PUSH;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else if (aw_idx_q == EVT_IDX) begin
          clr_mask = wdata_q & strb_mask;
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      W_PUSH: begin
        if (tx_ready) begin
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // New pulses are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    evt_d = (evt_q & ~clr_mask) | evt_i;
    irq_d = |evt_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    arready  = 1'b0;
    ar_hs    = 1'b0;

    unique case (rstate_q)
      R_IDLE: begin
        arready = live_q;
        ar_hs   = arvalid & live_q;
        if (ar_hs) begin
          rstate_d = R_DATA;
          rresp_d  = RESP_OKAY;
          rdata_d  = '0;
          if (ar_idx < TX_IDX) begin
            for (int k = 0; k < NREG; k++) begin
              if (ar_idx == IDX_W'(k)) begin
                rdata_d = cfg_q[k];
              end
            end
          end else if (ar_idx == TX_IDX) begin
            rdata_d = '0;
          end else if (ar_idx == EVT_IDX) begin
            rdata_d = evt_q;
          end else begin
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (rready) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign live_d = 1'b1;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      tx_data_q <= '0;
      evt_q     <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int k = 0; k < NREG; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      live_q    <= live_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      tx_data_q <= tx_data_d;
      evt_q     <= evt_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int k = 0; k < NREG; k++) begin
        cfg_q[k] <= cfg_d[k];
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_cfg_o
    assign cfg_o[k*DATA_W +: DATA_W] = cfg_q[k];
  end

  assign bvalid   = (wstate_q == W_RESP);
  assign bresp    = bresp_q;
  assign tx_valid = (wstate_q == W_PUSH);
  assign tx_data  = tx_data_q;
  assign rvalid   = (rstate_q == R_DATA);
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_cbi980_axil_regs.sv
// tb/tb_cbi980_axil_regs.sv - directed and randomized bench for cbi980_axil_regs
module tb_cbi980_axil_regs;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NREG   = 4;

  logic                   aclk = 1'b0;
  logic                   arst = 1'b1;
  logic [ADDR_W-1:0]      awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ADDR_W-1:0]      araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DATA_W-1:0]      rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic [NREG*DATA_W-1:0] cfg_o;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [DATA_W-1:0]      evt_i;
  logic                   irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_cfg [NREG];
  logic [31:0] m_evt;

  cbi980_axil_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .aclk(aclk), .arst(arst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cfg_o(cfg_o), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .evt_i(evt_i), .irq(irq)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m + (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic chk_cfg(input string tag);
    for (int k = 0; k < NREG; k++) chk($sformatf("%s_cfg%0d", tag, k), cfg_o[k*32 +: 32], m_cfg[k]);
  endtask

  task automatic write_hs(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done;
    bit w_done;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (aw_done && !w_done) chk("awready_drop", awready, 0);
      if (w_done && !aw_done) chk("wready_drop", wready, 0);
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge aclk);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("write_hs_done", 64'(aw_done && w_done), 1);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int cyc;
    cyc = 0;
    bready = 1;
    while (!bvalid && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    chk("bvalid_seen", bvalid, 1);
    resp = bresp;
    @(negedge aclk);
    bready = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    write_hs(a, d, s, aw_dly, w_dly);
    wait_b(resp);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int cyc;
    bit done;
    cyc = 0; done = 0;
    araddr = a; arvalid = 1;
    while (!done && cyc < 50) begin
      done = arready;
      @(negedge aclk);
      cyc++;
    end
    arvalid = 0;
    chk("ar_done", done, 1);
    chk("rvalid_latency", rvalid, 1);
    cyc = 0;
    while (!rvalid && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    d = rdata; resp = rresp;
    rready = 1;
    @(negedge aclk);
    rready = 0;
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          idx, idx2;
    logic [7:0]  a;
    logic [31:0] wd, ev, exp_d;
    logic [3:0]  s;
    logic [1:0]  exp_r;

    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0; tx_ready = 0; evt_i = 0;
    for (int k = 0; k < NREG; k++) m_cfg[k] = 0;
    m_evt = 0;

    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cfg", 64'(|cfg_o), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    arst = 0;
    #1 chk("rel_awready_first_edge", awready, 0);
    @(negedge aclk);
    chk("live_awready", awready, 1);
    chk("live_wready", wready, 1);
    chk("live_arready", arready, 1);

    // CFG write with AW and W together, latency and read-back
    awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    chk("b_lat_T1", bvalid, 0);
    chk("awready_exec", awready, 0);
    @(negedge aclk);
    chk("b_lat_T2", bvalid, 1);
    chk("b_resp_cfg", bresp, 0);
    m_cfg[1] = 32'hDEADBEEF;
    chk("cfg1_deadbeef", cfg_o[63:32], 32'hDEADBEEF);
    bready = 1;
    @(negedge aclk);
    bready = 0;
    do_read(8'h04, d, r);
    chk("rd_cfg1_data", d, 32'hDEADBEEF);
    chk("rd_cfg1_resp", r, 0);

    // Partial strobe with W leading AW by three cycles
    do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    m_cfg[0] = 32'hFFFFFFFF;
    do_write(8'h00, 32'h11223344, 4'h5, 3, 0, r);
    chk("partial_resp", r, 0);
    chk("cfg0_partial", cfg_o[31:0], 32'hFF22FF44);
    m_cfg[0] = 32'hFF22FF44;
    chk_cfg("after_partial");

    // TXDATA push stalled five cycles
    tx_ready = 0;
    write_hs(8'h10, 32'h00ABCDEF, 4'hF, 0, 0);
    chk("tx_exec_not_valid", tx_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      chk($sformatf("tx_valid_c%0d", i), tx_valid, 1);
      chk($sformatf("tx_data_c%0d", i), tx_data, 32'h00ABCDEF);
      chk($sformatf("tx_nob_c%0d", i), bvalid, 0);
      if (i == 5) tx_ready = 1;
    end
    @(negedge aclk);
    tx_ready = 0;
    chk("tx_done_valid", tx_valid, 0);
    chk("tx_done_bvalid", bvalid, 1);
    wait_b(r);
    chk("tx_resp", r, 0);
    do_read(8'h10, d, r);
    chk("rd_tx_data", d, 0);
    chk("rd_tx_resp", r, 0);

    // TXDATA with a clear strobe must not push
    write_hs(8'h10, 32'h00ABCDEF, 4'h7, 0, 0);
    chk("tx_bad_exec", tx_valid, 0);
    wait_b(r);
    chk("tx_bad_resp", r, 2);
    chk("tx_bad_valid", tx_valid, 0);

    // Out-of-range index
    do_write(8'h18, 32'h12345678, 4'hF, 0, 0, r);
    chk("oor_bresp", r, 2);
    chk_cfg("oor");
    do_read(8'h18, d, r);
    chk("oor_rdata", d, 0);
    chk("oor_rresp", r, 2);

    // EVENT sticky bits, set-wins on coincident clear, W1C
    evt_i = 32'h3;
    @(negedge aclk);
    evt_i = 0;
    m_evt = 32'h3;
    chk("evt_irq_set", irq, 1);
    do_read(8'h14, d, r);
    chk("evt_rd_3", d, 32'h3);
    write_hs(8'h14, 32'h1, 4'hF, 0, 0);
    evt_i = 32'h1;
    @(negedge aclk);
    evt_i = 0;
    wait_b(r);
    chk("evt_w1c_resp", r, 0);
    do_read(8'h14, d, r);
    chk("evt_set_wins", d, 32'h3);
    chk("evt_irq_held", irq, 1);
    do_write(8'h14, 32'h3, 4'hF, 0, 0, r);
    m_evt = 0;
    chk("evt_irq_clr", irq, 0);
    do_read(8'h14, d, r);
    chk("evt_rd_0", d, 0);

    // Randomized accesses against the register model
    tx_ready = 1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ev = $urandom & $urandom;
        evt_i = ev;
        @(negedge aclk);
        evt_i = 0;
        m_evt = m_evt | ev;
      end
      idx = $urandom_range(0, 7);
      a  = 8'(idx * 4 + $urandom_range(0, 3));
      wd = $urandom;
      s  = 4'($urandom_range(0, 15));
      if (idx == NREG && $urandom_range(0, 1) == 1) s = 4'hF;
      do_write(a, wd, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
      exp_r = 2'b10;
      if (idx < NREG) begin
        m_cfg[idx] = (m_cfg[idx] & ~byte_mask(s)) | (wd & byte_mask(s));
        exp_r = 0;
      end else if (idx == NREG) begin
        if (s == 4'hF) begin
          exp_r = 0;
          chk("rnd_tx_data", tx_data, wd);
        end
      end else if (idx == NREG + 1) begin
        m_evt = m_evt & ~(wd & byte_mask(s));
        exp_r = 0;
      end
      chk("rnd_bresp", r, exp_r);
      chk_cfg("rnd");
      chk("rnd_irq", irq, 64'(m_evt != 0));

      idx2 = $urandom_range(0, 7);
      do_read(8'(idx2 * 4 + $urandom_range(0, 3)), d, r);
      exp_d = 0; exp_r = 0;
      if (idx2 < NREG) exp_d = m_cfg[idx2];
      else if (idx2 == NREG + 1) exp_d = m_evt;
      else if (idx2 > NREG + 1) exp_r = 2'b10;
      chk("rnd_rdata", d, exp_d);
      chk("rnd_rresp", r, exp_r);
    end

    // Reset while a push and a read response are both pending
    tx_ready = 0;
    write_hs(8'h10, 32'hCAFEF00D, 4'hF, 0, 0);
    @(negedge aclk);
    chk("mid_tx_valid", tx_valid, 1);
    araddr = 8'h04; arvalid = 1;
    @(negedge aclk);
    arvalid = 0;
    chk("mid_rvalid", rvalid, 1);
    #2 arst = 1;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_bvalid", bvalid, 0);
    chk("arst_cfg", 64'(|cfg_o), 0);
    chk("arst_irq", irq, 0);
    chk("arst_awready", awready, 0);
    chk("arst_arready", arready, 0);
    for (int k = 0; k < NREG; k++) m_cfg[k] = 0;
    m_evt = 0;
    @(negedge aclk);
    arst = 0;
    #1;
    chk("rel2_awready", awready, 0);
    chk("rel2_wready", wready, 0);
    chk("rel2_arready", arready, 0);
    @(negedge aclk);
    chk("rel2_live_awready", awready, 1);
    chk("rel2_live_arready", arready, 1);
    do_read(8'h04, d, r);
    chk("post_rst_cfg1", d, 0);
    chk_cfg("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cbi980_axil_regs.md
Name: cbi980_axil_regs

Overview:
Parametrised AXI4-Lite slave front-end for the CBI980 I2S core, the successor to the single fixed-width AXI4-Lite controller. It provides a configurable-width register bank and byte-strobe writes. AW and W are accepted independently, in either order. Out-of-range and illegal accesses return SLVERR. A back-pressured TX sample push port feeds the I2S serialiser, and sticky event flags drive an interrupt.

Parameters:
DATA_W, 32, AXI data width; 32 or 64.
ADDR_W, 8, AXI address width; must address at least NREG+2 words.
NREG, 4, number of RW config registers; 1..16.

Ports:
aclk  in  1  clock
arst  in  1  asynchronous active-high reset
awaddr  in  ADDR_W  write address
awprot  in  3  ignored
awvalid/awready  in/out  1  AW handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes
wvalid/wready  in/out  1  W handshake
bresp  out  2  00 OKAY, 10 SLVERR
bvalid/bready  out/in  1  B handshake
araddr  in  ADDR_W  read address
arprot  in  3  ignored
arvalid/arready  in/out  1  AR handshake
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR
rvalid/rready  out/in  1  R handshake
cfg_o  out  NREG*DATA_W  config registers, reg k at bits [k*DATA_W +: DATA_W]
tx_data  out  DATA_W  sample to I2S core
tx_valid/tx_ready  out/in  1  sample handshake
evt_i  in  DATA_W  event pulses, one cycle each
irq  out  1  OR of sticky event bits

Behaviour:
- Word index = addr[ADDR_W-1 : log2(DATA_W/8)]; low address bits are ignored.
- Index 0..NREG-1 is CFG[k]: RW, reset 0, byte lanes written per wstrb.
- Index NREG is TXDATA:
  - Write with all strobes set pushes the sample.
  - Write with any strobe clear returns SLVERR and does not push.
  - Read returns 0 with OKAY.
- Index NREG+1 is EVENT:
  - Bit i set on evt_i[i].
  - Write-1-to-clear per strobed byte.
  - Set and clear of the same bit in the same cycle: set wins.
  - Read returns the sticky value with OKAY.
- Any other index: write returns SLVERR with no side effect; read returns rdata=0 with SLVERR.
- Reset (async, arst high):
  - All state to idle; CFG, EVENT, rdata, tx_data = 0.
  - bvalid, rvalid, tx_valid, irq = 0; bresp = rresp = 00.
  - awready, wready, arready = 0 while arst is high and on the first edge after release. They rise one cycle after release via a registered "live" flag.
- Reset mid-transaction drops the transaction. tx_valid falls asynchronously.
- Write FSM states: W_IDLE, W_EXEC, W_PUSH, W_RESP.
  - W_IDLE:
    - awready = live & ~aw_held; wready = live & ~w_held.
    - Each handshake latches its payload and sets its held flag; either order or the same cycle.
    - When both are held, or complete this cycle: go to W_EXEC.
  - W_EXEC (1 cycle):
    - Decode, compute bresp, apply CFG/EVENT writes at the end of the cycle.
    - Legal TXDATA goes to W_PUSH; everything else goes to W_RESP.
  - W_PUSH:
    - tx_valid = 1; tx_data holds the latched wdata.
    - On tx_ready, go to W_RESP. Stall is unbounded.
  - W_RESP:
    - bvalid = 1; bresp stable until bready.
    - On bready, clear the held flags and go to W_IDLE.
  - Latency: AW+W in the same cycle T gives bvalid at T+2 for a CFG write; CFG visible on cfg_o at T+2.
  - No new AW/W is accepted until the B handshake completes.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = live. On handshake at T, register rdata/rresp from the state at T; rvalid = 1 at T+1.
  - R_DATA: rdata/rresp held stable until rready, then go to R_IDLE; arready returns the next cycle.
- Read and write FSMs run concurrently.
  - A read of EVENT captured in the same cycle a W1C applies returns the pre-clear value.
  - A read of CFG in the same cycle it is written returns the old value.
- irq = |EVENT, registered; it follows the EVENT register with 0 extra latency.

Test Plan:
- CFG write/read: AW and W same cycle, addr 0x04, wdata 0xDEADBEEF, wstrb 0xF (DATA_W=32). Required: bvalid at T+2, bresp 00; cfg_o[63:32] = 0xDEADBEEF; read 0x04 returns 0xDEADBEEF, OKAY, rvalid one cycle after AR.
- Partial strobe and AW/W order: W (0x11223344, wstrb 0x5) then AW to 0x00 three cycles later, with CFG0 = 0xFFFFFFFF. Required: CFG0 = 0xFF22FF44; each ready drops after its own handshake.
- TXDATA push: write 0x00ABCDEF to index NREG, tx_ready low 5 cycles. Required: tx_valid high with tx_data = 0x00ABCDEF for 6 cycles; bvalid only after the tx_ready cycle. Same write with wstrb 0x7: SLVERR, tx_valid never rises.
- Errors: write then read of index NREG+2. Required: bresp 10, rresp 10 with rdata 0, no register changes.
- EVENT: pulse evt_i = 0x3 → irq = 1. Write 0x1 to EVENT while pulsing evt_i = 0x1 in the same cycle → EVENT stays 0x3. Next write of 0x3 with no pulse → EVENT 0, irq 0.
- Reset: assert arst during W_PUSH and R_DATA. Required: tx_valid, rvalid, bvalid fall immediately; CFG = 0; readies stay 0 until one cycle after release.
